// File: rtl/iic_master_drv.sv
// iic_master_drv: byte-level I2C master for the PCF8563 RTC controller.
// Generates the 4x SCL pacing clock and runs single-byte write / random-read transfers.
module iic_master_drv #(
  parameter logic [6:0] DEVICE_ADDR  = 7'h51,
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 250_000
) (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic        iic_start,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        addr_num,
  input  logic [15:0] byte_addr,
  input  logic [7:0]  wr_data,
  output logic        iic_clk,
  output logic        iic_end,
  output logic [7:0]  rd_data,
  output logic        ack_err,
  output logic        iic_scl,
  inout  wire         iic_sda
);

  localparam int CNT_CLK_MAX = SYS_CLK_FREQ / (SCL_FREQ * 8);
  localparam int CW = (CNT_CLK_MAX > 1) ? $clog2(CNT_CLK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_CLK_MAX - 1);

  typedef enum logic [3:0] {
    IDLE, START_1, SEND_D_ADDR, ACK_1,
    SEND_B_ADDR_H, ACK_2, SEND_B_ADDR_L, ACK_3,
    WR_DATA, ACK_4, START_2, SEND_RD_ADDR,
    ACK_5, RD_DATA, N_ACK, STOP
  } state_e;

  logic [CW-1:0] cnt_clk_q, cnt_clk_d;
  logic          iic_clk_q, iic_clk_d;
  state_e        state_q, state_d;
  logic [1:0]    cnt_qtr_q, cnt_qtr_d;
  logic [2:0]    cnt_bit_q, cnt_bit_d;
  logic          wr_q, wr_d;
  logic          addr16_q, addr16_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rx_q, rx_d;
  logic          err_q, err_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          iic_end_q, iic_end_d;
  logic          ack_err_q, ack_err_d;

  logic       tick;
  logic       qtr_end;
  logic       bit_end;
  logic       is_ack;
  logic       is_byte;
  logic       sda_in;
  logic       sda_out;
  logic       scl_mid;
  logic [7:0] tx_byte;

  assign sda_in  = iic_sda;
  assign iic_sda = sda_out ? 1'bz : 1'b0;
  assign iic_clk = iic_clk_q;
  assign iic_end = iic_end_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_data_q;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt_clk_q <= '0;
      iic_clk_q <= 1'b1;
      state_q   <= IDLE;
      cnt_qtr_q <= '0;
      cnt_bit_q <= '0;
      wr_q      <= 1'b0;
      addr16_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      iic_end_q <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      cnt_clk_q <= cnt_clk_d;
      iic_clk_q <= iic_clk_d;
      state_q   <= state_d;
      cnt_qtr_q <= cnt_qtr_d;
      cnt_bit_q <= cnt_bit_d;
      wr_q      <= wr_d;
      addr16_q  <= addr16_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      iic_end_q <= iic_end_d;
      ack_err_q <= ack_err_d;
    end
  end

  always_comb begin
    cnt_clk_d = (cnt_clk_q == CNT_LAST) ? '0 : cnt_clk_q + CW'(1);
    iic_clk_d = (cnt_clk_q == CNT_LAST) ? ~iic_clk_q : iic_clk_q;
    tick      = (cnt_clk_q == CNT_LAST) && !iic_clk_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_qtr_d = cnt_qtr_q;
    cnt_bit_d = cnt_bit_q;
    wr_d      = wr_q;
    addr16_d  = addr16_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    iic_end_d = iic_end_q;
    ack_err_d = ack_err_q;
    qtr_end   = (cnt_qtr_q == 2'd3);
    bit_end   = qtr_end && (cnt_bit_q == 3'd0);
    is_ack    = state_q inside {ACK_1, ACK_2, ACK_3, ACK_4, ACK_5};
    is_byte   = state_q inside {SEND_D_ADDR, SEND_B_ADDR_H, SEND_B_ADDR_L,
                                WR_DATA, SEND_RD_ADDR, RD_DATA};
    if (tick) begin
      iic_end_d = 1'b0;
      ack_err_d = 1'b0;
      if (state_q != IDLE) cnt_qtr_d = cnt_qtr_q + 2'd1;
      // 3-bit down-count wraps 0->7 at each byte boundary
      if (is_byte && qtr_end) cnt_bit_d = cnt_bit_q - 3'd1;
      if (is_ack && cnt_qtr_q == 2'd2 && sda_in) err_d = 1'b1;
      if (state_q == RD_DATA && cnt_qtr_q == 2'd2) rx_d = {rx_q[6:0], sda_in};
      unique case (state_q)
        IDLE: begin
          if (iic_start && (wr_en ^ rd_en)) begin
            state_d   = START_1;
            cnt_qtr_d = 2'd0;
            cnt_bit_d = 3'd7;
            wr_d      = wr_en;
            addr16_d  = addr_num;
            addr_d    = byte_addr;
            wdata_d   = wr_data;
            err_d     = 1'b0;
          end
        end
        START_1:       if (qtr_end) state_d = SEND_D_ADDR;
        SEND_D_ADDR:   if (bit_end) state_d = ACK_1;
        ACK_1:
          if (qtr_end)
            state_d = err_q ? STOP : (addr16_q ? SEND_B_ADDR_H : SEND_B_ADDR_L);
        SEND_B_ADDR_H: if (bit_end) state_d = ACK_2;
        ACK_2:         if (qtr_end) state_d = err_q ? STOP : SEND_B_ADDR_L;
        SEND_B_ADDR_L: if (bit_end) state_d = ACK_3;
        ACK_3:
          if (qtr_end) state_d = err_q ? STOP : (wr_q ? WR_DATA : START_2);
        WR_DATA:       if (bit_end) state_d = ACK_4;
        ACK_4:         if (qtr_end) state_d = STOP;
        START_2:       if (qtr_end) state_d = SEND_RD_ADDR;
        SEND_RD_ADDR:  if (bit_end) state_d = ACK_5;
        ACK_5:         if (qtr_end) state_d = err_q ? STOP : RD_DATA;
        RD_DATA: begin
          if (bit_end) begin
            state_d   = N_ACK;
            rd_data_d = rx_q;
          end
        end
        N_ACK:         if (qtr_end) state_d = STOP;
        STOP: begin
          if (qtr_end) begin
            state_d   = IDLE;
            iic_end_d = 1'b1;
            ack_err_d = err_q;
          end
        end
      endcase
    end
  end

  always_comb begin
    tx_byte = 8'hff;
    unique case (state_q)
      SEND_D_ADDR:   tx_byte = {DEVICE_ADDR, 1'b0};
      SEND_B_ADDR_H: tx_byte = addr_q[15:8];
      SEND_B_ADDR_L: tx_byte = addr_q[7:0];
      WR_DATA:       tx_byte = wdata_q;
      SEND_RD_ADDR:  tx_byte = {DEVICE_ADDR, 1'b1};
      default:       tx_byte = 8'hff;
    endcase
  end

  always_comb begin
    scl_mid = (cnt_qtr_q == 2'd1) || (cnt_qtr_q == 2'd2);
    iic_scl = scl_mid;
    sda_out = 1'b1;
    unique case (state_q)
      IDLE: begin
        iic_scl = 1'b1;
        sda_out = 1'b1;
      end
      START_1: begin
        iic_scl = (cnt_qtr_q != 2'd3);
        sda_out = (cnt_qtr_q == 2'd0);
      end
      START_2: begin
        iic_scl = scl_mid;
        sda_out = !cnt_qtr_q[1];
      end
      SEND_D_ADDR, SEND_B_ADDR_H, SEND_B_ADDR_L, WR_DATA, SEND_RD_ADDR: begin
        iic_scl = scl_mid;
        sda_out = tx_byte[cnt_bit_q];
      end
      STOP: begin
        iic_scl = (cnt_qtr_q != 2'd0);
        sda_out = cnt_qtr_q[1];
      end
      default: begin
        iic_scl = scl_mid;
        sda_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_iic_master_drv.sv
// tb_iic_master_drv: directed + randomized transfers against a bus-level slave model.
// Expected bytes, durations and results come from transaction-level rules.
module tb_iic_master_drv;

  localparam int SYS_F = 20_000_000;
  localparam int SCL_F = 250_000;
  localparam int HALF  = SYS_F / (SCL_F * 8);
  localparam logic [6:0] DEV = 7'h51;

  logic        sys_clk   = 1'b0;
  logic        sys_rstn  = 1'b0;
  logic        iic_start = 1'b0;
  logic        wr_en     = 1'b0;
  logic        rd_en     = 1'b0;
  logic        addr_num  = 1'b0;
  logic [15:0] byte_addr = '0;
  logic [7:0]  wr_data   = '0;
  logic        iic_clk, iic_end, ack_err, iic_scl;
  logic [7:0]  rd_data;
  wire         iic_sda;
  logic        slv_low = 1'b0;

  pullup (iic_sda);
  assign iic_sda = slv_low ? 1'b0 : 1'bz;

  iic_master_drv #(
    .DEVICE_ADDR (DEV),
    .SYS_CLK_FREQ(SYS_F),
    .SCL_FREQ    (SCL_F)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .iic_start(iic_start),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr_num (addr_num),
    .byte_addr(byte_addr),
    .wr_data  (wr_data),
    .iic_clk  (iic_clk),
    .iic_end  (iic_end),
    .rd_data  (rd_data),
    .ack_err  (ack_err),
    .iic_scl  (iic_scl),
    .iic_sda  (iic_sda)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input string name,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, name, obs, exp);
    end
  endtask

  // Slave model: decodes START/STOP/bits from sampled bus, ACKs, serves reads
  logic       pscl = 1'b1, psda = 1'b1, scl_now, sda_now;
  int         starts = 0, stops = 0, scl_falls = 0;
  logic [7:0] got[$];
  logic [7:0] sh = '0;
  int         bitcnt = 0, bidx = 0;
  bit         ack_ph = 0, tx = 0, tx_next = 0, m_slot = 0;
  logic [7:0] rbyte = '0;
  bit         nack_dev = 0;
  logic       m_ack = 1'b0;

  always @(negedge sys_clk) begin
    scl_now = iic_scl;
    sda_now = iic_sda;
    if (pscl && scl_now && psda && !sda_now) begin
      starts++;
      bitcnt = 0; bidx = 0; ack_ph = 0; tx = 0; tx_next = 0; m_slot = 0;
      slv_low = 1'b0;
    end else if (pscl && scl_now && !psda && sda_now) begin
      stops++;
      bitcnt = 0; ack_ph = 0; tx = 0; tx_next = 0; m_slot = 0;
      slv_low = 1'b0;
    end else if (!pscl && scl_now) begin
      if (ack_ph) begin
        if (m_slot) m_ack = sda_now;
      end else if (bitcnt < 8) begin
        sh = {sh[6:0], sda_now};
        bitcnt++;
      end
    end else if (pscl && !scl_now) begin
      scl_falls++;
      if (ack_ph) begin
        ack_ph = 0; m_slot = 0; bitcnt = 0; slv_low = 1'b0;
        if (tx_next) begin
          tx = 1; tx_next = 0;
          slv_low = !rbyte[7];
        end
      end else if (bitcnt == 8) begin
        ack_ph = 1;
        if (tx) begin
          tx = 0; m_slot = 1; slv_low = 1'b0;
        end else begin
          got.push_back(sh);
          slv_low = !(nack_dev && bidx == 0);
          if (bidx == 0 && sh[0] && slv_low) tx_next = 1;
          bidx++;
        end
      end else if (tx) begin
        slv_low = !rbyte[7 - bitcnt];
      end
    end
    pscl = scl_now;
    psda = sda_now;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] last_rd = 8'h00;

  task automatic run_txn(input string tag, input bit w, input bit a16,
                         input logic [15:0] ad, input logic [7:0] wd,
                         input logic [7:0] rb, input bit nk);
    logic [7:0] exp_q[$];
    int exp_ticks, exp_starts, n, s0, p0;
    logic [7:0] exp_rd;
    bit seen;
    exp_q.push_back({DEV, 1'b0});
    if (nk) begin
      exp_ticks  = 4 + 36 + 4;
      exp_starts = 1;
      exp_rd     = last_rd;
    end else begin
      if (a16) exp_q.push_back(ad[15:8]);
      exp_q.push_back(ad[7:0]);
      exp_q.push_back(w ? wd : {DEV, 1'b1});
      exp_ticks  = 4 + 36 * exp_q.size() + 4 + (w ? 0 : 40);
      exp_starts = w ? 1 : 2;
      exp_rd     = w ? last_rd : rb;
    end
    got.delete();
    rbyte = rb; nack_dev = nk; m_ack = 1'b0;
    s0 = starts; p0 = stops;
    @(negedge iic_clk);
    wr_en = w; rd_en = !w; addr_num = a16;
    byte_addr = ad; wr_data = wd; iic_start = 1'b1;
    @(posedge iic_clk); #1;
    iic_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(posedge iic_clk); #1;
      n++;
      if (iic_end) seen = 1;
    end
    chk(tag, "end_seen", seen, 1);
    chk(tag, "ticks", n, exp_ticks);
    chk(tag, "ack_err", ack_err, nk);
    chk(tag, "rd_data", rd_data, exp_rd);
    @(negedge iic_clk); #1;
    chk(tag, "end_hold", iic_end, 1);
    @(posedge iic_clk); #1;
    chk(tag, "end_clr", iic_end, 0);
    chk(tag, "err_clr", ack_err, 0);
    chk(tag, "nbytes", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(tag, $sformatf("byte%0d", i), got[i], exp_q[i]);
    chk(tag, "starts", starts - s0, exp_starts);
    chk(tag, "stops", stops - p0, 1);
    if (!w && !nk) chk(tag, "master_nack", m_ack, 1);
    chk(tag, "idle_scl", iic_scl, 1);
    chk(tag, "idle_sda", iic_sda, 1);
    last_rd = exp_rd;
  endtask

  initial begin
    longint t1, t2, t3;
    int s0, f0;
    bit w, a16, nk;
    #23;
    chk("reset", "iic_clk", iic_clk, 1);
    chk("reset", "scl", iic_scl, 1);
    chk("reset", "sda", iic_sda, 1);
    chk("reset", "iic_end", iic_end, 0);
    chk("reset", "ack_err", ack_err, 0);
    chk("reset", "rd_data", rd_data, 8'h00);
    @(negedge sys_clk);
    sys_rstn = 1'b1;

    @(posedge iic_clk); t1 = $time;
    @(negedge iic_clk); t2 = $time;
    @(posedge iic_clk); t3 = $time;
    chk("clk", "period", 32'((t3 - t1) / 10), 2 * HALF);
    chk("clk", "high", 32'((t2 - t1) / 10), HALF);
    chk("clk", "idle_scl", iic_scl, 1);
    chk("clk", "idle_sda", iic_sda, 1);

    run_txn("wr8", 1, 0, 16'h0002, 8'h10, 8'h00, 0);
    run_txn("rd8", 0, 0, 16'h0004, 8'h00, 8'h59, 0);
    run_txn("nack", 1, 0, 16'h0007, 8'h3c, 8'h00, 1);
    run_txn("wr16", 1, 1, 16'h1234, 8'h5a, 8'h00, 0);

    s0 = starts; f0 = scl_falls;
    @(negedge iic_clk);
    wr_en = 1'b1; rd_en = 1'b1; iic_start = 1'b1;
    @(posedge iic_clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    @(posedge iic_clk); #1;
    iic_start = 1'b0;
    repeat (20) @(posedge iic_clk);
    #1;
    chk("illegal", "starts", starts - s0, 0);
    chk("illegal", "scl_falls", scl_falls - f0, 0);
    chk("illegal", "iic_end", iic_end, 0);

    @(negedge iic_clk);
    wr_en = 1'b1; addr_num = 1'b0; byte_addr = 16'h0009;
    wr_data = 8'h00; iic_start = 1'b1;
    @(posedge iic_clk); #1;
    iic_start = 1'b0; wr_en = 1'b0;
    repeat (90) @(posedge iic_clk);
    @(negedge sys_clk);
    chk("midrst", "sda_busy", iic_sda, 0);
    sys_rstn = 1'b0;
    #1;
    chk("midrst", "scl", iic_scl, 1);
    chk("midrst", "sda", iic_sda, 1);
    chk("midrst", "iic_end", iic_end, 0);
    chk("midrst", "iic_clk", iic_clk, 1);
    chk("midrst", "rd_data", rd_data, 8'h00);
    last_rd = 8'h00;
    repeat (3) @(negedge sys_clk);
    sys_rstn = 1'b1;

    run_txn("post_rst", 1, 0, 16'h0002, 8'h10, 8'h00, 0);

    for (int k = 0; k < 4; k++) begin
      w   = 1'($urandom_range(0, 1));
      a16 = 1'($urandom_range(0, 1));
      nk  = ($urandom_range(0, 3) == 0);
      run_txn($sformatf("rnd%0d", k), w, a16, 16'($urandom),
              8'($urandom), 8'($urandom), nk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
